// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add unsigned multiplier: captures an operand pair, iterates once per
// multiplier bit, then presents the registered 2W-bit product with a one-cycle pulse.
module shift_add_multiplier #(
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inputs_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]  in1,
  input  logic [INPUT_DATA_WIDTH-1:0]  in2,
  output logic [OUTPUT_DATA_WIDTH-1:0] out,
  output logic                         output_valid,
  output logic                         busy
);

  localparam int W        = INPUT_DATA_WIDTH;
  localparam int PW       = 2 * INPUT_DATA_WIDTH;
  localparam int CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  if (OUTPUT_DATA_WIDTH != 2 * INPUT_DATA_WIDTH) begin : g_bad_width
    $error("OUTPUT_DATA_WIDTH must equal 2*INPUT_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  // Add into the upper half with one extra bit so the carry survives the shift.
  logic [W:0]      sum;
  logic [PW-1:0]   acc_next;

  always_comb begin
    sum      = {1'b0, acc[PW-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[W-1:1]};
  end

  // NOTE: every register here uses <= so all updates see pre-edge values; the
  // datapath registers are few and reset with the FSM, so nothing starts as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      out          <= '0;
      output_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (inputs_valid) begin
            mcand  <= in1;
            mplier <= in2;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          out          <= acc;
          output_valid <= 1'b1;
          if (inputs_valid) begin
            mcand  <= in1;
            mplier <= in2;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed and random operand pairs against
// plain 64-bit multiplication, with latency, busy, overlap and reset scenarios.
module tb_shift_add_multiplier;

  localparam int W  = 32;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inputs_valid = 1'b0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic [PW-1:0] out;
  logic          output_valid;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    int            cyc;
    logic [PW-1:0] data;
  } pulse_t;
  pulse_t pulses[$];

  shift_add_multiplier #(.INPUT_DATA_WIDTH(W), .OUTPUT_DATA_WIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .inputs_valid (inputs_valid),
    .in1          (in1),
    .in2          (in2),
    .out          (out),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (output_valid) pulses.push_back('{cyc: cyc, data: out});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Must be called at a negedge; returns the cycle index of the capture edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int e0);
    in1 = a;
    in2 = b;
    inputs_valid = 1'b1;
    @(negedge clk);
    e0 = cyc;
    inputs_valid = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
  endtask

  task automatic check_op(input string name, input int e0, input logic [PW-1:0] exp);
    int bad_busy = 0;
    int bad_at = -1;
    while (cyc < e0 + W + 3) begin
      if (busy !== ((cyc - e0) < W)) begin
        bad_busy++;
        if (bad_at < 0) bad_at = cyc - e0;
      end
      @(negedge clk);
    end
    total++;
    if (bad_busy != 0)
      $display("FAIL %s busy: %0d wrong cycles, first at offset %0d (high required for offsets 0..%0d)",
               name, bad_busy, bad_at, W - 1);
    else passed++;
    total++;
    if (pulses.size() != 1)
      $display("FAIL %s pulse_count: got %0d pulses, required 1", name, pulses.size());
    else passed++;
    if (pulses.size() > 0) begin
      total++;
      if (pulses[0].cyc - e0 != W + 1)
        $display("FAIL %s latency: got %0d edges, required %0d", name, pulses[0].cyc - e0, W + 1);
      else passed++;
      total++;
      if (pulses[0].data !== exp)
        $display("FAIL %s product: got 0x%016h, required 0x%016h", name, pulses[0].data, exp);
      else passed++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int e0;
    @(negedge clk);
    pulses.delete();
    start_op(a, b, e0);
    check_op(name, e0, model(a, b));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (out !== '0) $display("FAIL reset_out: got 0x%016h, required 0", out); else passed++;
    total++;
    if (output_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", output_valid); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    // Inputs released together with reset must be captured on the first clean edge.
    begin
      int e0;
      reset = 1'b0;
      pulses.delete();
      start_op(32'd3, 32'd5, e0);
      check_op("first_edge_3x5", e0, 64'h0000_0000_0000_000F);
    end
  endtask

  task automatic test_directed();
    do_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("zero_x_deadbeef", 32'h0, 32'hDEAD_BEEF);
    do_op("x_times_one", 32'h1234_5678, 32'h1);
    do_op("msb_x_msb", 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a = $urandom;
      logic [W-1:0] b = $urandom;
      do_op($sformatf("random_%0d", i), a, b);
    end
  endtask

  task automatic test_ignore_during_run();
    int e0;
    @(negedge clk);
    pulses.delete();
    start_op(32'd3, 32'd5, e0);
    wait_until(e0 + 9);
    in1 = 32'd7;
    in2 = 32'd9;
    inputs_valid = 1'b1;
    @(negedge clk);
    inputs_valid = 1'b0;
    wait_until(e0 + W + 41);
    total++;
    if (pulses.size() != 1)
      $display("FAIL ignore_run pulse_count: got %0d, required 1", pulses.size());
    else passed++;
    if (pulses.size() > 0) begin
      total++;
      if (pulses[0].data !== 64'd15 || pulses[0].cyc - e0 != W + 1)
        $display("FAIL ignore_run result: got 0x%016h at offset %0d, required 0x%016h at %0d",
                 pulses[0].data, pulses[0].cyc - e0, 64'd15, W + 1);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    @(negedge clk);
    pulses.delete();
    start_op(32'd3, 32'd5, e0);
    wait_until(e0 + W);
    in1 = 32'd2;
    in2 = 32'd4;
    inputs_valid = 1'b1;
    @(negedge clk);
    inputs_valid = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_restart: got %b, required 1", busy); else passed++;
    wait_until(e0 + 2 * W + 5);
    total++;
    if (pulses.size() != 2)
      $display("FAIL b2b pulse_count: got %0d, required 2", pulses.size());
    else passed++;
    if (pulses.size() >= 2) begin
      total++;
      if (pulses[0].data !== 64'd15 || pulses[0].cyc - e0 != W + 1)
        $display("FAIL b2b first: got 0x%016h at offset %0d, required 0x%016h at %0d",
                 pulses[0].data, pulses[0].cyc - e0, 64'd15, W + 1);
      else passed++;
      total++;
      if (pulses[1].data !== 64'd8 || pulses[1].cyc - pulses[0].cyc != W + 1)
        $display("FAIL b2b second: got 0x%016h after %0d edges, required 0x%016h after %0d",
                 pulses[1].data, pulses[1].cyc - pulses[0].cyc, 64'd8, W + 1);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    int e0;
    @(negedge clk);
    pulses.delete();
    start_op(32'd3, 32'd5, e0);
    wait_until(e0 + 11);
    reset = 1'b1;
    #1;
    total++;
    if (out !== '0 || output_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset outputs: got out=0x%016h valid=%b busy=%b, required 0/0/0",
               out, output_valid, busy);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (pulses.size() != 0)
      $display("FAIL mid_reset no_pulse: got %0d pulses, required 0", pulses.size());
    else passed++;
    do_op("after_reset", 32'hCAFE_F00D, 32'h0BAD_BEEF);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
